// File: rtl/pc_predict_pkg.sv
// Shared types and helpers for the IF-stage next-PC generator.
package pc_predict_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

  // RUN fetches normally; JALR_WAIT emits bubbles until EX resolves the JALR target.
  typedef enum logic [1:0] {
    PC_STATE_RUN       = 2'b00,
    PC_STATE_JALR_WAIT = 2'b01
  } pc_state_e;

  // Static BTFN prediction: JAL always taken, conditional branch taken only when
  // its displacement is negative (backward loop edge).
  function automatic logic pred_hit(input logic en, input logic jal,
                                    input logic bxx, input addr_t imm);
    return en & (jal | (bxx & imm[ADDR_W-1]));
  endfunction

endpackage

// File: rtl/pc_predict_if.sv
// Fetch-side bundle between the IF-stage pre-decode / pipeline control and the
// next-PC generator. The master drives decode flags, stall and redirect; the
// slave (pc_predict) returns the fetch PC and its per-instruction qualifiers.
interface pc_predict_if;
  import pc_predict_pkg::*;

  logic  inst_valid_i;
  logic  inst_jal_i;
  logic  inst_jalr_i;
  logic  inst_bxx_i;
  addr_t jb_imm_i;
  logic  hold_i;
  logic  jump_flag_i;
  addr_t jump_addr_i;
  addr_t pc_o;
  logic  pred_taken_o;
  logic  fetch_valid_o;

  modport master (
    output inst_valid_i, inst_jal_i, inst_jalr_i, inst_bxx_i, jb_imm_i,
           hold_i, jump_flag_i, jump_addr_i,
    input  pc_o, pred_taken_o, fetch_valid_o
  );

  modport slave (
    input  inst_valid_i, inst_jal_i, inst_jalr_i, inst_bxx_i, jb_imm_i,
           hold_i, jump_flag_i, jump_addr_i,
    output pc_o, pred_taken_o, fetch_valid_o
  );

endinterface

// File: rtl/pc_predict.sv
// IF-stage next-PC generator with static branch prediction. Owns the fetch PC,
// looks at the pre-decode of the instruction currently at pc_o and selects the
// next fetch address: EX redirect, hold, predicted target or sequential pc+4.
module pc_predict
  import pc_predict_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT,
  parameter bit    PRED_EN  = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  pc_predict_if.slave bus
);

  pc_state_e state_q;
  pc_state_e state_d;
  addr_t     pc_q;
  addr_t     pc_d;
  addr_t     pc_plus4;
  addr_t     pc_target;
  logic      hit;
  logic      pred_taken;
  logic      fetch_valid;

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + bus.jb_imm_i;
  assign hit       = pred_hit(PRED_EN, bus.inst_jal_i, bus.inst_bxx_i, bus.jb_imm_i);

  // Next-PC priority mux: a redirect kills everything; otherwise outputs describe
  // the instruction at pc_q and a hold merely blocks the register update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pred_taken  = 1'b0;
    fetch_valid = 1'b0;
    if (bus.jump_flag_i) begin
      pc_d    = bus.jump_addr_i;
      state_d = PC_STATE_RUN;
    end else begin
      if (state_q == PC_STATE_RUN && bus.inst_valid_i) begin
        fetch_valid = 1'b1;
        if (bus.inst_jalr_i) begin
          state_d = PC_STATE_JALR_WAIT;
        end else if (hit) begin
          pred_taken = 1'b1;
          pc_d       = pc_target;
        end else begin
          pc_d = pc_plus4;
        end
      end
      if (bus.hold_i) begin
        pc_d    = pc_q;
        state_d = state_q;
      end
    end
  end

  // Fetch PC and JALR-wait state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= PC_STATE_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pred_taken_o  = pred_taken;
  assign bus.fetch_valid_o = fetch_valid;

endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict: one predicting and one non-predicting instance
// share the same stimulus; a behavioural model pushes the expected post-edge PC
// into a scoreboard queue that is drained after each clock edge.
module tb_pc_predict;
  import pc_predict_pkg::*;

  typedef struct {
    string tag;
    addr_t pc_pred;
    addr_t pc_nopred;
  } exp_t;

  logic  clk;
  logic  rst_n;
  int    total;
  int    passed;
  exp_t  sb_q[$];
  addr_t m_pc[2];
  bit    m_wait[2];

  pc_predict_if bus ();
  pc_predict_if bus_np ();

  pc_predict #(.RESET_PC(32'h0000_0000), .PRED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  pc_predict #(.RESET_PC(32'h0000_0000), .PRED_EN(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .bus(bus_np.slave)
  );

  assign bus_np.inst_valid_i = bus.inst_valid_i;
  assign bus_np.inst_jal_i   = bus.inst_jal_i;
  assign bus_np.inst_jalr_i  = bus.inst_jalr_i;
  assign bus_np.inst_bxx_i   = bus.inst_bxx_i;
  assign bus_np.jb_imm_i     = bus.jb_imm_i;
  assign bus_np.hold_i       = bus.hold_i;
  assign bus_np.jump_flag_i  = bus.jump_flag_i;
  assign bus_np.jump_addr_i  = bus.jump_addr_i;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input addr_t actual, input addr_t expected);
    total++;
    assert (actual === expected) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, actual, expected);
  endtask

  // Behavioural priority list: returns combinational outputs and next PC/state.
  task automatic modelStep(input int k, input bit pe, input bit valid, input bit jal,
                           input bit jalr, input bit bxx, input addr_t imm,
                           input bit hold, input bit jf, input addr_t ja,
                           output bit pt, output bit fv,
                           output addr_t npc, output bit nwait);
    pt    = 1'b0;
    fv    = 1'b0;
    npc   = m_pc[k];
    nwait = m_wait[k];
    if (jf) begin
      npc   = ja;
      nwait = 1'b0;
    end else if (!m_wait[k] && valid) begin
      fv = 1'b1;
      if (jalr) begin
        if (!hold) nwait = 1'b1;
      end else if (pe && (jal || (bxx && imm[31]))) begin
        pt = 1'b1;
        if (!hold) npc = m_pc[k] + imm;
      end else begin
        if (!hold) npc = m_pc[k] + 32'd4;
      end
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]   = 32'h0000_0000;
      m_wait[k] = 1'b0;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      $error("[TB] FAIL scoreboard: observed empty queue expected one entry");
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, " pc pred"}, bus.pc_o, e.pc_pred);
    check({e.tag, " pc nopred"}, bus_np.pc_o, e.pc_nopred);
  endtask

  // Drives one cycle of inputs (called just after a falling edge), checks the
  // combinational outputs, queues the expected PC, then checks after the edge.
  task automatic applyStimulus(input string tag, input bit valid, input bit jal,
                               input bit jalr, input bit bxx, input addr_t imm,
                               input bit hold, input bit jf, input addr_t ja);
    bit    pt[2];
    bit    fv[2];
    addr_t npc[2];
    bit    nwait[2];
    exp_t  e;
    bus.inst_valid_i = valid;
    bus.inst_jal_i   = jal;
    bus.inst_jalr_i  = jalr;
    bus.inst_bxx_i   = bxx;
    bus.jb_imm_i     = imm;
    bus.hold_i       = hold;
    bus.jump_flag_i  = jf;
    bus.jump_addr_i  = ja;
    #1;
    for (int k = 0; k < 2; k++)
      modelStep(k, (k == 0), valid, jal, jalr, bxx, imm, hold, jf, ja,
                pt[k], fv[k], npc[k], nwait[k]);
    check({tag, " pred_taken pred"}, {31'd0, bus.pred_taken_o}, {31'd0, pt[0]});
    check({tag, " fetch_valid pred"}, {31'd0, bus.fetch_valid_o}, {31'd0, fv[0]});
    check({tag, " pred_taken nopred"}, {31'd0, bus_np.pred_taken_o}, {31'd0, pt[1]});
    check({tag, " fetch_valid nopred"}, {31'd0, bus_np.fetch_valid_o}, {31'd0, fv[1]});
    e.tag       = tag;
    e.pc_pred   = npc[0];
    e.pc_nopred = npc[1];
    sb_q.push_back(e);
    for (int k = 0; k < 2; k++) begin
      m_pc[k]   = npc[k];
      m_wait[k] = nwait[k];
    end
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic plain(input string tag);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic redirect(input string tag, input addr_t ja);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ja);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    bus.inst_valid_i = 1'b1;
    bus.inst_jal_i   = 1'b0;
    bus.inst_jalr_i  = 1'b0;
    bus.inst_bxx_i   = 1'b0;
    bus.jb_imm_i     = 32'h0;
    bus.hold_i       = 1'b0;
    bus.jump_flag_i  = 1'b0;
    bus.jump_addr_i  = 32'h0;
    modelReset();

    // Reset values while reset is held.
    #2;
    check("reset pc", bus.pc_o, 32'h0);
    check("reset pred_taken", {31'd0, bus.pred_taken_o}, 32'h0);
    check("reset fetch_valid", {31'd0, bus.fetch_valid_o}, 32'h1);
    bus.inst_valid_i = 1'b0;
    #1;
    check("reset fetch_valid low", {31'd0, bus.fetch_valid_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch.
    check("t1 pc0", bus.pc_o, 32'h0);
    plain("t1 step0");
    check("t1 pc4", bus.pc_o, 32'h4);
    plain("t1 step1");
    check("t1 pc8", bus.pc_o, 32'h8);
    plain("t1 step2");
    check("t1 pcC", bus.pc_o, 32'hC);
    plain("t1 step3");

    // Backward branch predicted taken, forward not taken.
    redirect("t2 go100", 32'h100);
    applyStimulus("t2 bxx back", 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0);
    check("t2 back target", bus.pc_o, 32'h0000_00F0);
    check("t2 back nopred", bus_np.pc_o, 32'h0000_0104);
    redirect("t2 go100b", 32'h100);
    applyStimulus("t2 bxx fwd", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0);
    check("t2 fwd seq", bus.pc_o, 32'h0000_0104);

    // JAL under hold for two cycles, then released.
    redirect("t3 go200", 32'h200);
    applyStimulus("t3 jal hold0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 1'b1, 1'b0, 32'h0);
    applyStimulus("t3 jal hold1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 1'b1, 1'b0, 32'h0);
    check("t3 held pc", bus.pc_o, 32'h200);
    applyStimulus("t3 jal go", 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 1'b0, 1'b0, 32'h0);
    check("t3 jal target", bus.pc_o, 32'h600);

    // JALR issues once, bubbles until EX redirects.
    redirect("t4 go300", 32'h300);
    applyStimulus("t4 jalr", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    plain("t4 wait0");
    plain("t4 wait1");
    plain("t4 wait2");
    check("t4 wait pc", bus.pc_o, 32'h300);
    redirect("t4 resolve", 32'h1234);
    check("t4 resolved pc", bus.pc_o, 32'h1234);
    plain("t4 resume");

    // Redirect beats prediction and hold; decode jalr+jal conflict resolves to jalr.
    redirect("t5 go400", 32'h400);
    applyStimulus("t5 jal+jf", 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 32'h900);
    check("t5 redirect pc", bus.pc_o, 32'h900);
    redirect("t5 go400b", 32'h400);
    applyStimulus("t5 jal+jf+hold", 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 1'b1, 32'h900);
    check("t5 redirect hold pc", bus.pc_o, 32'h900);
    applyStimulus("t5 jalr+jal", 1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h0);
    applyStimulus("t5 invalid", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h500);
    applyStimulus("t5 invalid run", 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0);

    // Wraparound, then async reset in the middle of a JALR wait.
    redirect("t6 goTop", 32'hFFFF_FFFC);
    plain("t6 wrap");
    check("t6 wrap pc", bus.pc_o, 32'h0);
    redirect("t6 go300", 32'h300);
    applyStimulus("t6 jalr", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    plain("t6 wait");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    check("t6 async reset pc", bus.pc_o, 32'h0);
    check("t6 async reset nopred pc", bus_np.pc_o, 32'h0);
    check("t6 reset fetch_valid", {31'd0, bus.fetch_valid_o}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    plain("t6 after reset");
    check("t6 run pc", bus.pc_o, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
